// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin RAM arbiter/sequencer (define ARB_FIXED_PRIORITY_EN for fixed port-0 priority)
module ram_arbiter #(
  parameter int MEM_WORD_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [3:0]  byte_enable,
  output logic [31:0] addr,
  output logic [31:0] w_data,
  input  logic [31:0] r_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic owner, we_q, err_q, sel, acc;
  logic [3:0] be_q;
  logic [29:0] word_q;
  logic [31:0] wdata_q, rdata_q, req_addr, resp_data;
`ifdef ARB_FIXED_PRIORITY_EN
  assign sel = m1_req & ~m0_req;
`else
  logic last_grant;
  assign sel = m1_req & (~m0_req | ~last_grant);
`endif
  assign acc = (state == IDLE) & (m0_req | m1_req) & ~reset;
  assign m0_gnt = acc & ~sel;
  assign m1_gnt = acc & sel;
  assign req_addr = sel ? m1_addr : m0_addr;
  assign resp_data = (we_q | err_q) ? 32'd0 : rdata_q;
  always_comb begin
    state_n = IDLE;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    byte_enable = 4'd0;
    addr = 32'd0;
    w_data = 32'd0;
    m0_rvalid = 1'b0;
    m0_rdata = 32'd0;
    m0_err = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata = 32'd0;
    m1_err = 1'b0;
    if (state == IDLE) begin
      state_n = acc ? ACCESS : IDLE;
    end else if (state == ACCESS) begin
      state_n = RESP;
      MemRead = ~we_q & ~err_q;
      MemWrite = we_q & ~err_q;
      byte_enable = we_q ? be_q : 4'd0;
      addr = {2'b00, word_q};
      w_data = wdata_q;
    end else if (state == RESP) begin
      m0_rvalid = ~owner;
      m0_rdata = owner ? 32'd0 : resp_data;
      m0_err = ~owner & err_q;
      m1_rvalid = owner;
      m1_rdata = owner ? resp_data : 32'd0;
      m1_err = owner & err_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= 1'b0;
      we_q <= 1'b0;
      be_q <= 4'd0;
      word_q <= 30'd0;
      wdata_q <= 32'd0;
      err_q <= 1'b0;
      rdata_q <= 32'd0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_n;
      if (acc) begin
        owner <= sel;
        we_q <= sel ? m1_we : m0_we;
        be_q <= sel ? m1_be : m0_be;
        word_q <= req_addr[31:2];
        wdata_q <= sel ? m1_wdata : m0_wdata;
        err_q <= (req_addr[1:0] != 2'b00) | ({2'b00, req_addr[31:2]} >= 32'(MEM_WORD_SIZE));
`ifndef ARB_FIXED_PRIORITY_EN
        last_grant <= sel;
`endif
      end
      if (state == ACCESS && !we_q && !err_q) rdata_q <= r_data;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench with a transaction-level reference model of the arbiter and RAM
module tb_ram_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [3:0] m0_be, m1_be, byte_enable;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic MemRead, MemWrite;
  logic [31:0] addr, w_data, r_data;
  ram_arbiter #(.MEM_WORD_SIZE(256)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .byte_enable(byte_enable), .addr(addr),
    .w_data(w_data), .r_data(r_data)
  );
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  assign r_data = ram[addr[7:0]];
  always @(posedge clk)
    if (MemWrite)
      for (int b = 0; b < 4; b++)
        if (byte_enable[b]) ram[addr[7:0]][8*b +: 8] <= w_data[8*b +: 8];
  int checks = 0, fails = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction
  typedef struct packed {logic port; logic err; logic [31:0] rdata;} resp_t;
  resp_t resp_q[$];
  int busy = 0;
  logic last = 1'b1, own, any_g, w, f_we, e_err, a_rd, a_wr;
  logic [3:0] f_be, a_be;
  logic [31:0] f_a, f_wd, a_addr, a_wd;
  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      last = 1'b1;
      resp_q.delete();
    end else begin
      any_g = 1'b0;
      w = 1'b0;
      if (busy == 0 && (m0_req || m1_req)) begin
        any_g = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
        w = !m0_req;
`else
        w = (m0_req && m1_req) ? !last : !m0_req;
`endif
      end
      check("gnt0", m0_gnt, any_g && !w);
      check("gnt1", m1_gnt, any_g && w);
      if (busy == 2) begin
        check("acc_rd", MemRead, a_rd);
        check("acc_wr", MemWrite, a_wr);
        check("acc_be", byte_enable, a_be);
        check("acc_addr", addr, a_addr);
        check("acc_wdata", w_data, a_wd);
      end else begin
        check("ram_quiet_ctl", {MemRead, MemWrite, byte_enable}, 0);
        check("ram_quiet_bus", addr | w_data, 0);
      end
      if (busy == 1) begin
        check("rvalid", {m1_rvalid, m0_rvalid}, own ? 2 : 1);
        if (a_wr) ref_mem[a_addr[7:0]] = merge(ref_mem[a_addr[7:0]], a_wd, a_be);
      end else check("rvalid_quiet", {m1_rvalid, m0_rvalid}, 0);
      if (busy > 0) busy--;
      if (any_g) begin
        f_we = w ? m1_we : m0_we;
        f_be = w ? m1_be : m0_be;
        f_a = w ? m1_addr : m0_addr;
        f_wd = w ? m1_wdata : m0_wdata;
        e_err = (f_a[1:0] != 0) || (f_a[31:2] >= 256);
        a_rd = !f_we && !e_err;
        a_wr = f_we && !e_err;
        a_addr = {2'b00, f_a[31:2]};
        a_be = f_we ? f_be : 4'd0;
        a_wd = f_wd;
        resp_q.push_back('{w, e_err, a_rd ? ref_mem[f_a[9:2]] : 32'd0});
        last = w;
        own = w;
        busy = 2;
      end
    end
  end
  resp_t r;
  always @(negedge clk) begin
    if (!reset) begin
      if (!m0_rvalid) check("quiet0", m0_rdata | {31'd0, m0_err}, 0);
      if (!m1_rvalid) check("quiet1", m1_rdata | {31'd0, m1_err}, 0);
      if (m0_rvalid || m1_rvalid) begin
        if (resp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp: got rvalid=%b%b expected none", m1_rvalid, m0_rvalid);
        end else begin
          r = resp_q.pop_front();
          check("resp_port", m1_rvalid, r.port);
          check("resp_rdata", m1_rvalid ? m1_rdata : m0_rdata, r.rdata);
          check("resp_err", m1_rvalid ? m1_err : m0_err, r.err);
        end
      end
    end
  end
  task automatic drive(input int p, input logic rq, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      m0_req = rq; m0_we = we; m0_be = be; m0_addr = a; m0_wdata = wd;
    end else begin
      m1_req = rq; m1_we = we; m1_be = be; m1_addr = a; m1_wdata = wd;
    end
  endtask
  logic s_rd, s_wr, s_rv, s_err;
  logic [3:0] s_be;
  logic [31:0] s_addr, s_rdata;
  task automatic wait_gnt(input int p);
    int n = 0;
    @(negedge clk);
    while (!(p == 1 ? m1_gnt : m0_gnt) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      fails++;
      $display("FAIL gnt_timeout: got no gnt%0d expected gnt within 20 cycles", p);
    end
  endtask
  task automatic issue(input int p, input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    drive(p, 1'b1, we, be, a, wd);
    wait_gnt(p);
    @(posedge clk); #1;
    drive(p, 1'b0, we, be, a, wd);
    @(negedge clk);
    s_rd = MemRead; s_wr = MemWrite; s_be = byte_enable; s_addr = addr;
    @(negedge clk);
    s_rv = p == 1 ? m1_rvalid : m0_rvalid;
    s_rdata = p == 1 ? m1_rdata : m0_rdata;
    s_err = p == 1 ? m1_err : m0_err;
    @(posedge clk); #1;
  endtask
  int gseq[$];
  logic [31:0] old5, rnd_a;
  logic g[2];
  logic pend[2];
  int bad;
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = (i * 32'h01010101) ^ 32'h5A00C3F0;
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    drive(0, 1'b1, 1'b0, 4'd0, 32'h10, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("reset_gnt", {m0_gnt, m1_gnt}, 0);
    check("reset_ram", {MemRead, MemWrite, byte_enable} | addr | w_data, 0);
    check("reset_rsp", {m0_rvalid, m1_rvalid, m0_err, m1_err} | m0_rdata | m1_rdata, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 32'h10, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    issue(0, 1'b0, 4'd0, 32'h10, 32'd0);
    check("t1_memread", s_rd, 1);
    check("t1_addr", s_addr, 4);
    check("t1_rvalid", s_rv, 1);
    check("t1_rdata", s_rdata, 32'hDEADBEEF);
    check("t1_err", s_err, 0);
    issue(1, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
    check("t2_memwrite", s_wr, 1);
    check("t2_be", s_be, 4'b0101);
    issue(1, 1'b0, 4'd0, 32'h20, 32'd0);
    check("t2_rdata", s_rdata, 32'h11BB33DD);
    drive(0, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
    drive(1, 1'b1, 1'b0, 4'd0, 32'h18, 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (m0_gnt) gseq.push_back(0);
      if (m1_gnt) gseq.push_back(1);
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 32'h14, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'h18, 32'd0);
    check("t3_ngrants", gseq.size(), 4);
    if (gseq.size() == 4)
`ifdef ARB_FIXED_PRIORITY_EN
      check("t3_order", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0000);
`else
      check("t3_order", {gseq[0][0], gseq[1][0], gseq[2][0], gseq[3][0]}, 4'b0101);
`endif
    repeat (3) @(posedge clk); #1;
    issue(0, 1'b0, 4'd0, 32'h402, 32'd0);
    check("t4a_ctl", {s_rd, s_wr}, 0);
    check("t4a_resp", {s_rv, s_err}, 2'b11);
    check("t4a_rdata", s_rdata, 0);
    issue(0, 1'b0, 4'd0, 32'h400, 32'd0);
    check("t4b_ctl", {s_rd, s_wr}, 0);
    check("t4b_resp", {s_rv, s_err}, 2'b11);
    check("t4b_rdata", s_rdata, 0);
    drive(1, 1'b1, 1'b0, 4'd0, 32'h30, 32'd0);
    wait_gnt(1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 4'd0, 32'h30, 32'd0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 4'hF, 32'h3C, 32'hCAFEF00D);
    @(negedge clk);
    check("t5_wait_gnt0", m0_gnt, 0);
    check("t5_m1_rvalid", m1_rvalid, 1);
    @(negedge clk);
    check("t5_gnt0", m0_gnt, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 4'hF, 32'h3C, 32'hCAFEF00D);
    @(negedge clk);
    check("t5_acc", {MemWrite, byte_enable, addr, w_data}, {1'b1, 4'hF, 32'hF, 32'hCAFEF00D});
    repeat (2) @(posedge clk); #1;
    old5 = ram[5];
    drive(0, 1'b1, 1'b1, 4'hF, 32'h14, 32'h12345678);
    wait_gnt(0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 4'hF, 32'h14, 32'h12345678);
    @(negedge clk);
    check("t6_memwrite_pre", MemWrite, 1);
    #1 reset = 1'b1;
    #1 check("t6_memwrite_async", MemWrite, 0);
    @(negedge clk);
    check("t6_no_rvalid", m0_rvalid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 4'd0, 32'h14, 32'd0);
    drive(1, 1'b1, 1'b0, 4'd0, 32'h18, 32'd0);
    @(negedge clk);
    check("t6_tie_after_reset", {m1_gnt, m0_gnt}, 2'b01);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'd0, 32'h14, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'h18, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("t6_no_store", ram[5], old5);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g[0] = m0_gnt;
      g[1] = m1_gnt;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && (g[p] || $urandom_range(0, 15) == 0)) begin
          pend[p] = 1'b0;
          drive(p, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        end
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1;
          rnd_a = {$urandom_range(0, 263), 2'b00};
          if ($urandom_range(0, 7) == 0) rnd_a[1:0] = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 31) == 0) rnd_a[31] = 1'b1;
          drive(p, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_a, $urandom);
        end
      end
    end
    drive(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (4) @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("mem_final", bad, 0);
    check("resp_q_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port, word-aligned data RAM with byte enables.
- Requester 0 is the CPU load/store path; requester 1 is the DMA/debug port.
- Accepts one request at a time through a req/gnt handshake and drives the RAM control, byte-enable, address and write-data lines.
- Returns a one-cycle response carrying read data, or an error flag for illegal addresses.
- Sits between the requesters and the RAM; it is the only driver of the RAM's MemRead/MemWrite.

## Interface
Parameters:
- MEM_WORD_SIZE, 256, RAM depth in 32-bit words; legal word index is 0..MEM_WORD_SIZE-1.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock.
  - reset  in  1  reset, asynchronous, active-high.
- Requester ports, for n in {0,1}:
  - mN_req  in  1  request.
  - mN_we  in  1  1 = store, 0 = load.
  - mN_be  in  4  byte enables for stores; ignored on loads.
  - mN_addr  in  32  byte address.
  - mN_wdata  in  32  store data.
  - mN_gnt  out  1  request accepted this cycle.
  - mN_rvalid  out  1  response valid, one cycle.
  - mN_rdata  out  32  load data.
  - mN_err  out  1  response is an error.
- RAM side:
  - MemRead  out  1  RAM read enable.
  - MemWrite  out  1  RAM write enable.
  - byte_enable  out  4  RAM byte enables.
  - addr  out  32  RAM word index.
  - w_data  out  32  RAM write data.
  - r_data  in  32  RAM combinational read data.

## Operation
FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.

IDLE:
- Grant selection:
  - mN_gnt = (state==IDLE) & selected winner. Grant is combinational.
  - Only one gnt is high at a time.
  - A single requester wins if it is the only one requesting.
  - If both request, arbitration is round-robin: the port not in last_grant wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- At the edge where gnt=1:
  - Latch we, be, addr, wdata and owner.
  - Compute the error bit: err = (addr[1:0]!=0) | (addr[31:2] >= MEM_WORD_SIZE).
  - last_grant <= owner.
  - Go to ACCESS.
- Requester fields must be stable while req=1 and gnt=0. A requester may drop req before gnt with no side effect.

ACCESS (one cycle):
- addr = {2'b00, latched_addr[31:2]}.
- w_data = latched wdata.
- byte_enable = latched be on stores, 4'b0000 on loads.
- MemWrite = we & !err.
- MemRead = !we & !err.
- On a load, r_data is captured into rdata_q at the end of the cycle. The store commits at the same edge.
- Go to RESP.

RESP (one cycle):
- Owner's rvalid = 1.
- rdata = rdata_q on loads, 0 on stores or on error.
- err = latched error bit.
- The non-owner's rvalid = 0.
- Go to IDLE.

Outputs and boundary conditions:
- All RAM outputs are 0 outside ACCESS.
- mN_rdata and mN_err are 0 whenever mN_rvalid = 0.
- A store with be = 0000 still performs the full sequence and acknowledges, with no memory change.
- Errored access: RAM is untouched; rvalid=1, err=1, rdata=0.
- A req arriving in ACCESS or RESP waits; gnt stays 0 until IDLE.

## Timing
- Latency:
  - Accept edge = T.
  - RAM access during cycle T+1.
  - rvalid high during cycle T+2.
  - Earliest next gnt in cycle T+3.
- Peak throughput: one transaction per 3 cycles.
- Reset values: all outputs 0; state IDLE; last_grant = 1; latched registers 0.
- Reset asserted mid-transaction:
  - Outputs go to 0 immediately (asynchronous).
  - An in-flight transaction is dropped with no rvalid.
  - A store is not performed unless the write edge occurred before reset assertion.
  - The requester must reissue.
- Exactly one rvalid pulse per gnt, absent reset.

## Configuration
- Macro ARB_FIXED_PRIORITY_EN.
  - Defined: port 0 always wins ties. last_grant is unused and port 1 can starve.
  - Undefined (default): round-robin as described above.

## Test plan
- m0 load of addr 0x10 with mem[4]=0xDEADBEEF:
  - gnt0 in cycle T, MemRead=1 and addr=4 in T+1, rvalid0=1 with rdata0=0xDEADBEEF and err0=0 in T+2.
- m1 store of 0xAABBCCDD to 0x20 with be=0101 over mem[8]=0x11223344, then m1 load of 0x20:
  - MemWrite=1 and byte_enable=0101 during ACCESS; the load returns 0x11BB33DD.
- Both requesters hold req continuously for 4 transactions:
  - Grants alternate 0,1,0,1.
  - With ARB_FIXED_PRIORITY_EN, grants are 0,0,0,0 and gnt1 is never high.
- m0 load of 0x00000402 (misaligned) and of 0x00000400 (word 256, out of range):
  - MemRead and MemWrite stay 0; rvalid0=1, err0=1, rdata0=0.
- reset asserted during the ACCESS cycle of an m0 store:
  - MemWrite falls to 0 immediately; no rvalid0.
  - After reset release, state is IDLE and port 0 wins the first tie.
- m0 req asserted during RESP of an m1 transaction:
  - gnt0 is low until IDLE, then high.
  - m0 fields held stable are accepted unchanged.
